axil_regbank_sync: RTL and testbench
====================================

# axil_regbank_sync

Parametrised AXI4-Lite slave register bank, successor to the fixed four-register synchronizer slave interface. Provides NUM_REGS software-visible registers of C_S_AXI_DATA_WIDTH bits with byte strobes, per-register read-only status mapping, SLVERR decode for unmapped or protected accesses, and one-cycle update pulses toward user logic. Sits behind the AXI master/interconnect in the block design and drives the synchronizer datapath control inputs.

## Interface
- C_S_AXI_DATA_WIDTH, 32: data width; 32 or 64 only.
- C_NUM_REGS, 16: number of registers, 1..256.
- C_S_AXI_ADDR_WIDTH, 6: byte address width; must satisfy 2^(ADDR_W-log2(DW/8)) >= C_NUM_REGS.
- C_RO_MASK, 0: C_NUM_REGS-bit mask; bit i set makes register i read-only, sourced from status_in.
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  standard AXI4-Lite write-address channel (AWPROT ignored).
- S_AXI_WDATA/WSTRB/WVALID/WREADY  write-data channel; WSTRB width DW/8.
- S_AXI_BRESP/BVALID/BREADY  write-response channel.
- S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  read-address channel (ARPROT ignored).
- S_AXI_RDATA/RRESP/RVALID/RREADY  read-data channel.
- reg_out  out  C_NUM_REGS*DW  flattened register contents, register i at [i*DW +: DW]; RO slots drive 0.
- reg_wr_pulse  out  C_NUM_REGS  one-cycle strobe per successfully written register.
- status_in  in  C_NUM_REGS*DW  values returned for RO registers.

## Operation
- Word index = ADDR[ADDR_W-1 : log2(DW/8)]; low byte-offset bits ignored (no misalignment error).
- Write path: AW and W captured independently into one-entry holding registers; either may arrive first or in the same cycle.
- AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID.
- Commit: the cycle both are held, at the next edge: if index < C_NUM_REGS and RO_MASK[index]=0, bytes with WSTRB=1 update, others kept, BRESP=OKAY (2'b00); otherwise no update, BRESP=SLVERR (2'b10). Holding registers clear, BVALID=1.
- reg_wr_pulse[index] high for exactly the first BVALID cycle on OKAY writes only (WSTRB=0 still pulses).
- BVALID held with stable BRESP until BVALID&&BREADY edge; both READYs return high the following cycle.
- Read path: ARREADY = !RVALID. On AR handshake edge, RDATA/RRESP registered: RW register → stored value, OKAY; RO register → status_in slice sampled that edge, OKAY; index >= C_NUM_REGS → RDATA 0, SLVERR.
- RVALID, RDATA, RRESP stable until RVALID&&RREADY edge.
- Read and write channels fully independent; same-edge read capture and write commit to same register: read returns pre-write value.
- Status inputs are assumed synchronous to ACLK; no CDC inside this block.

## Timing
- Reset (ARESET high at an edge): all RW registers 0, holding registers empty, AWREADY/WREADY/ARREADY 0 during reset, BVALID/RVALID 0, BRESP/RRESP 0, RDATA 0, reg_wr_pulse 0. READYs go 1 the first cycle after ARESET deasserts.
- Reset mid-transaction: pending writes discarded without commit, outstanding responses dropped.
- Write latency: last of AW/W handshake at edge k → register updated and BVALID=1 after edge k+1.
- Read latency: AR handshake at edge k → RVALID=1 after edge k.
- Max throughput: one write per 3 cycles with BREADY tied high; one read per 2 cycles with RREADY tied high.
- BREADY/RREADY low: backpressure holds indefinitely; no further handshakes on the stalled channel.

## Test plan
- Sequential: write 0x1,0x2,0x3,0x4 to addresses 0x0,0x4,0x8,0xC, read back → RDATA matches, all RESP OKAY, reg_wr_pulse bits 0..3 each pulse once.
- Strobes: reg2=0xAABBCCDD, write 0x11223344 WSTRB=4'b0101 → read 0xAA22CC44.
- Ordering: W 3 cycles before AW, then AW 3 cycles before W → both commit, BVALID one cycle after later handshake.
- Errors: write to index C_NUM_REGS and to RO register (RO_MASK bit 5, status_in slot 5=0xDEADBEEF) → SLVERR, no pulse, no change; read index 5 → 0xDEADBEEF OKAY; read unmapped → 0, SLVERR.
- Backpressure/collision: BREADY/RREADY low 10 cycles → VALID and data held, READYs low; same-edge read and write commit to reg0 (old 0x5, new 0x9) → read returns 0x5, next read 0x9.
- Reset mid-write: AW accepted, ARESET asserted before W → after reset all registers 0, no BVALID, no pulse.

Source files
------------

// File: rtl/axil_regbank_sync.sv
// AXI4-Lite slave register bank: NUM_REGS words with byte strobes, read-only status
// slots, SLVERR decode for unmapped/RO accesses and one-cycle write pulses to user logic.
module axil_regbank_sync #(
  parameter int                    C_S_AXI_DATA_WIDTH = 32,
  parameter int                    C_NUM_REGS         = 16,
  parameter int                    C_S_AXI_ADDR_WIDTH = 6,
  parameter logic [C_NUM_REGS-1:0] C_RO_MASK          = '0
) (
  input  logic                                   ACLK,
  input  logic                                   ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [C_NUM_REGS-1:0]                  reg_wr_pulse,
  input  logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] status_in
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int STRB_W = DW / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - LSB;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DW-1:0]         r_regs [C_NUM_REGS];
  logic                  r_aw_held, r_w_held, r_bvalid, r_rvalid;
  logic                  r_awready, r_wready, r_arready;
  logic [IDX_W-1:0]      r_aw_idx;
  logic [DW-1:0]         r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic [1:0]            r_bresp, r_rresp;
  logic [DW-1:0]         r_rdata;
  logic [C_NUM_REGS-1:0] r_wr_pulse;

  logic             w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_wr_ok, w_rd_ok;
  logic             w_aw_held_nxt, w_w_held_nxt, w_bvalid_nxt, w_rvalid_nxt;
  logic [IDX_W-1:0] w_rd_idx;
  logic [DW-1:0]    w_rd_data;
  logic             w_unused;

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[LSB-1:0],
                      S_AXI_ARADDR[LSB-1:0], status_in};

  assign w_rd_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:LSB];
  assign w_aw_hs  = S_AXI_AWVALID & r_awready;
  assign w_w_hs   = S_AXI_WVALID & r_wready;
  assign w_ar_hs  = S_AXI_ARVALID & r_arready;
  // A write commits the edge after both halves are held; BVALID blocks new captures.
  assign w_commit = r_aw_held & r_w_held;

  assign w_aw_held_nxt = w_commit ? 1'b0 : (r_aw_held | w_aw_hs);
  assign w_w_held_nxt  = w_commit ? 1'b0 : (r_w_held | w_w_hs);
  assign w_bvalid_nxt  = w_commit ? 1'b1 : (r_bvalid & ~S_AXI_BREADY);
  assign w_rvalid_nxt  = w_ar_hs  ? 1'b1 : (r_rvalid & ~S_AXI_RREADY);

  always_comb begin
    w_wr_ok   = 1'b0;
    w_rd_ok   = 1'b0;
    w_rd_data = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      w_wr_ok   = w_wr_ok | ((r_aw_idx == IDX_W'(i)) & ~C_RO_MASK[i]);
      w_rd_ok   = w_rd_ok | (w_rd_idx == IDX_W'(i));
      w_rd_data = w_rd_data | ((w_rd_idx != IDX_W'(i)) ? '0 :
                               (C_RO_MASK[i] ? status_in[i*DW +: DW] : r_regs[i]));
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_arready <= 1'b0;
      r_aw_idx  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bresp   <= RESP_OKAY;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      r_aw_held <= w_aw_held_nxt;
      r_w_held  <= w_w_held_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_awready <= ~w_aw_held_nxt & ~w_bvalid_nxt;
      r_wready  <= ~w_w_held_nxt & ~w_bvalid_nxt;
      r_arready <= ~w_rvalid_nxt;
      if (w_aw_hs) r_aw_idx <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:LSB];
      if (w_w_hs) begin
        r_wdata <= S_AXI_WDATA;
        r_wstrb <= S_AXI_WSTRB;
      end
      if (w_commit) r_bresp <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
      // Read samples pre-commit register contents on a shared edge.
      if (w_ar_hs) begin
        r_rdata <= w_rd_data;
        r_rresp <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wr_pulse <= '0;
      for (int i = 0; i < C_NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_wr_pulse <= '0;
      for (int i = 0; i < C_NUM_REGS; i++) begin
        if (w_commit && w_wr_ok && (r_aw_idx == IDX_W'(i))) begin
          r_wr_pulse[i] <= 1'b1;
          for (int b = 0; b < STRB_W; b++) begin
            if (r_wstrb[b]) r_regs[i][b*8 +: 8] <= r_wdata[b*8 +: 8];
          end
        end
      end
    end
  end

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
    assign reg_out[g*DW +: DW] = C_RO_MASK[g] ? '0 : r_regs[g];
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign reg_wr_pulse  = r_wr_pulse;

endmodule

// File: tb/tb_axil_regbank_sync.sv
// Directed-vector bench for axil_regbank_sync: 16 x 32-bit registers, register 5 read-only.
module tb_axil_regbank_sync;
  localparam int DW = 32;
  localparam int NR = 16;
  localparam int AW = 7;

  logic              ACLK = 1'b0;
  logic              ARESET = 1'b1;
  logic [AW-1:0]     S_AXI_AWADDR = '0;
  logic [2:0]        S_AXI_AWPROT = 3'd0;
  logic              S_AXI_AWVALID = 1'b0;
  logic              S_AXI_AWREADY;
  logic [DW-1:0]     S_AXI_WDATA = '0;
  logic [DW/8-1:0]   S_AXI_WSTRB = '0;
  logic              S_AXI_WVALID = 1'b0;
  logic              S_AXI_WREADY;
  logic [1:0]        S_AXI_BRESP;
  logic              S_AXI_BVALID;
  logic              S_AXI_BREADY = 1'b1;
  logic [AW-1:0]     S_AXI_ARADDR = '0;
  logic [2:0]        S_AXI_ARPROT = 3'd0;
  logic              S_AXI_ARVALID = 1'b0;
  logic              S_AXI_ARREADY;
  logic [DW-1:0]     S_AXI_RDATA;
  logic [1:0]        S_AXI_RRESP;
  logic              S_AXI_RVALID;
  logic              S_AXI_RREADY = 1'b1;
  logic [NR*DW-1:0]  reg_out;
  logic [NR-1:0]     reg_wr_pulse;
  logic [NR*DW-1:0]  status_in;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_regs [NR];

  axil_regbank_sync #(
    .C_S_AXI_DATA_WIDTH(DW), .C_NUM_REGS(NR), .C_S_AXI_ADDR_WIDTH(AW),
    .C_RO_MASK(16'h0020)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse), .status_in(status_in)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NR; i++)
      chk($sformatf("%s_reg%0d", tag, i), reg_out[i*DW +: DW], exp_regs[i]);
  endtask

  // Returns at the first BVALID cycle; consumes the response only if BREADY is high.
  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic [15:0] pulse);
    bit aw_go, w_go, aw_hs, w_hs;
    int t;
    aw_go = 1'b1; w_go = 1'b1; t = 0;
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    while ((aw_go || w_go) && t < 20) begin
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      tick; t++;
      if (aw_hs) begin S_AXI_AWVALID = 1'b0; aw_go = 1'b0; end
      if (w_hs)  begin S_AXI_WVALID = 1'b0;  w_go = 1'b0;  end
    end
    if (aw_go || w_go) chk("wr_handshake_timeout", 32'd0, 32'd1);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    t = 0;
    while (!S_AXI_BVALID && t < 20) begin tick; t++; end
    if (!S_AXI_BVALID) chk("bvalid_timeout", 32'd0, 32'd1);
    resp = S_AXI_BRESP;
    pulse = reg_wr_pulse;
    if (S_AXI_BREADY) tick;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit hs;
    int t;
    t = 0;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    while (S_AXI_ARVALID && t < 20) begin
      hs = S_AXI_ARREADY;
      tick; t++;
      if (hs) S_AXI_ARVALID = 1'b0;
    end
    if (S_AXI_ARVALID) chk("rd_handshake_timeout", 32'd0, 32'd1);
    S_AXI_ARVALID = 1'b0;
    if (!S_AXI_RVALID) chk("rvalid_latency", 32'd0, 32'd1);
    d = S_AXI_RDATA;
    resp = S_AXI_RRESP;
    if (S_AXI_RREADY) tick;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [15:0] pulse;
    logic [31:0] rd;

    for (int i = 0; i < NR; i++) begin
      status_in[i*DW +: DW] = 32'h5A5A_0000 | 32'(i);
      exp_regs[i] = 32'h0;
    end
    status_in[5*DW +: DW] = 32'hDEAD_BEEF;

    tick; tick;
    chk("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
    chk("rst_wready",  32'(S_AXI_WREADY),  32'd0);
    chk("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
    chk("rst_bvalid",  32'(S_AXI_BVALID),  32'd0);
    chk("rst_rvalid",  32'(S_AXI_RVALID),  32'd0);
    chk("rst_rdata",   S_AXI_RDATA,        32'd0);
    chk("rst_pulse",   32'(reg_wr_pulse),  32'd0);
    chk("rst_regout",  {31'd0, |reg_out},  32'd0);
    ARESET = 1'b0;
    tick; tick;
    chk("post_rst_awready", 32'(S_AXI_AWREADY), 32'd1);
    chk("post_rst_arready", 32'(S_AXI_ARREADY), 32'd1);

    // Sequential writes and readback
    for (int i = 0; i < 4; i++) begin
      axi_write(7'(i*4), 32'(i+1), 4'hF, resp, pulse);
      exp_regs[i] = 32'(i+1);
      chk($sformatf("seq_bresp%0d", i), 32'(resp), 32'd0);
      chk($sformatf("seq_pulse%0d", i), 32'(pulse), 32'(16'd1 << i));
    end
    chk("seq_pulse_cleared", 32'(reg_wr_pulse), 32'd0);
    for (int i = 0; i < 4; i++) begin
      axi_read(7'(i*4), rd, resp);
      chk($sformatf("seq_rdata%0d", i), rd, 32'(i+1));
      chk($sformatf("seq_rresp%0d", i), 32'(resp), 32'd0);
    end

    // Byte strobes
    axi_write(7'h08, 32'hAABB_CCDD, 4'hF, resp, pulse);
    axi_write(7'h08, 32'h1122_3344, 4'b0101, resp, pulse);
    exp_regs[2] = 32'hAA22_CC44;
    axi_read(7'h08, rd, resp);
    chk("strb_rdata", rd, 32'hAA22_CC44);
    axi_write(7'h0C, 32'hFFFF_FFFF, 4'b0000, resp, pulse);
    chk("strb0_pulse", 32'(pulse), 32'h0000_0008);
    chk("strb0_bresp", 32'(resp), 32'd0);

    // W three cycles ahead of AW
    S_AXI_WDATA = 32'h66; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    chk("ordw_wready", 32'(S_AXI_WREADY), 32'd1);
    tick; S_AXI_WVALID = 1'b0;
    tick; tick; tick;
    chk("ordw_no_bvalid", 32'(S_AXI_BVALID), 32'd0);
    S_AXI_AWADDR = 7'h18; S_AXI_AWVALID = 1'b1;
    chk("ordw_awready", 32'(S_AXI_AWREADY), 32'd1);
    tick; S_AXI_AWVALID = 1'b0;
    chk("ordw_bvalid_k", 32'(S_AXI_BVALID), 32'd0);
    tick;
    chk("ordw_bvalid_k1", 32'(S_AXI_BVALID), 32'd1);
    chk("ordw_pulse", 32'(reg_wr_pulse), 32'h0000_0040);
    tick;
    exp_regs[6] = 32'h66;

    // AW three cycles ahead of W
    S_AXI_AWADDR = 7'h1C; S_AXI_AWVALID = 1'b1;
    tick; S_AXI_AWVALID = 1'b0;
    tick; tick; tick;
    chk("orda_no_bvalid", 32'(S_AXI_BVALID), 32'd0);
    S_AXI_WDATA = 32'h77; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    chk("orda_wready", 32'(S_AXI_WREADY), 32'd1);
    tick; S_AXI_WVALID = 1'b0;
    chk("orda_bvalid_k", 32'(S_AXI_BVALID), 32'd0);
    tick;
    chk("orda_bvalid_k1", 32'(S_AXI_BVALID), 32'd1);
    chk("orda_bresp", 32'(S_AXI_BRESP), 32'd0);
    tick;
    exp_regs[7] = 32'h77;

    // Unmapped and read-only accesses
    axi_write(7'h40, 32'hFFFF_FFFF, 4'hF, resp, pulse);
    chk("unmap_bresp", 32'(resp), 32'd2);
    chk("unmap_pulse", 32'(pulse), 32'd0);
    axi_write(7'h14, 32'h1234_5678, 4'hF, resp, pulse);
    chk("ro_bresp", 32'(resp), 32'd2);
    chk("ro_pulse", 32'(pulse), 32'd0);
    axi_read(7'h14, rd, resp);
    chk("ro_rdata", rd, 32'hDEAD_BEEF);
    chk("ro_rresp", 32'(resp), 32'd0);
    axi_read(7'h44, rd, resp);
    chk("unmap_rdata", rd, 32'd0);
    chk("unmap_rresp", 32'(resp), 32'd2);
    axi_read(7'h10, rd, resp);
    chk("rw4_rdata", rd, 32'd0);
    check_all("err");

    // Write response backpressure
    S_AXI_BREADY = 1'b0;
    axi_write(7'h04, 32'h1234, 4'hF, resp, pulse);
    exp_regs[1] = 32'h1234;
    repeat (10) tick;
    chk("bp_bvalid",  32'(S_AXI_BVALID),  32'd1);
    chk("bp_bresp",   32'(S_AXI_BRESP),   32'd0);
    chk("bp_awready", 32'(S_AXI_AWREADY), 32'd0);
    chk("bp_wready",  32'(S_AXI_WREADY),  32'd0);
    chk("bp_pulse",   32'(reg_wr_pulse),  32'd0);
    S_AXI_BREADY = 1'b1;
    tick;
    chk("bp_bvalid_drop", 32'(S_AXI_BVALID), 32'd0);
    chk("bp_awready_back", 32'(S_AXI_AWREADY), 32'd1);

    // Read data backpressure
    S_AXI_RREADY = 1'b0;
    axi_read(7'h04, rd, resp);
    chk("rbp_rdata0", rd, 32'h1234);
    repeat (10) tick;
    chk("rbp_rvalid",  32'(S_AXI_RVALID),  32'd1);
    chk("rbp_rdata",   S_AXI_RDATA,        32'h1234);
    chk("rbp_arready", 32'(S_AXI_ARREADY), 32'd0);
    S_AXI_RREADY = 1'b1;
    tick;
    chk("rbp_rvalid_drop", 32'(S_AXI_RVALID), 32'd0);

    // Read capture and write commit on the same edge
    axi_write(7'h00, 32'h5, 4'hF, resp, pulse);
    S_AXI_AWADDR = 7'h00; S_AXI_WDATA = 32'h9; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    tick;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_ARADDR = 7'h00; S_AXI_ARVALID = 1'b1;
    chk("coll_arready", 32'(S_AXI_ARREADY), 32'd1);
    tick;
    S_AXI_ARVALID = 1'b0;
    chk("coll_bvalid", 32'(S_AXI_BVALID), 32'd1);
    chk("coll_rvalid", 32'(S_AXI_RVALID), 32'd1);
    chk("coll_rdata_old", S_AXI_RDATA, 32'h5);
    tick;
    axi_read(7'h00, rd, resp);
    chk("coll_rdata_new", rd, 32'h9);
    exp_regs[0] = 32'h9;
    check_all("final");

    // Reset between AW and W: the held address must be discarded
    S_AXI_AWADDR = 7'h08; S_AXI_AWVALID = 1'b1;
    tick; S_AXI_AWVALID = 1'b0;
    ARESET = 1'b1;
    tick;
    chk("mid_rst_awready", 32'(S_AXI_AWREADY), 32'd0);
    chk("mid_rst_wready",  32'(S_AXI_WREADY),  32'd0);
    tick;
    ARESET = 1'b0;
    tick; tick;
    chk("mid_rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
    chk("mid_rst_pulse",  32'(reg_wr_pulse), 32'd0);
    S_AXI_WDATA = 32'hCAFE_F00D; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    chk("mid_rst_wready_back", 32'(S_AXI_WREADY), 32'd1);
    tick; S_AXI_WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("mid_rst_no_commit%0d", i), {31'd0, S_AXI_BVALID | (|reg_wr_pulse)}, 32'd0);
    end
    for (int i = 0; i < NR; i++) exp_regs[i] = 32'h0;
    check_all("mid_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
